// File: rtl/comma_aligner_20b.sv
// comma_aligner_20b: finds the K28.5 comma in a raw 20-bit deserializer
// stream, qualifies one bit offset and emits word-aligned 20-bit symbols.
module comma_aligner_20b #(
  parameter int DW         = 20,
  parameter int LOCK_CNT   = 3,
  parameter int UNLOCK_CNT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  output logic          locked,
  output logic [4:0]    offset,
  output logic          comma_det
);

  localparam logic [9:0] K_NEG  = 10'b0011111010;
  localparam logic [9:0] K_POS  = 10'b1100000101;
  localparam logic [2:0] LOCK_C = 3'(LOCK_CNT);
  localparam logic [2:0] UNLK_C = 3'(UNLOCK_CNT);

  typedef enum logic [1:0] {S_HUNT, S_VERIFY, S_LOCKED} state_t;

  state_t          state_q;
  logic [DW-1:0]   prv_q;
  logic [DW-1:0]   dout_q;
  logic            dout_valid_q;
  logic            locked_q;
  logic [4:0]      offset_q;
  logic            comma_det_q;
  logic [2:0]      cnt_q, mis_q;
  logic [2:0]      cnt_d, mis_d;

  logic [2*DW-1:0] win;
  logic [2*DW-1:0] win_sh;
  logic [DW-1:0]   cand_off;
  logic            off_match;
  logic            hit;
  logic [4:0]      s_hit;

  // Only the leading 10-bit symbol is compared, so alignment is per word.
  function automatic logic is_comma(input logic [9:0] sym);
    return (sym == K_NEG) || (sym == K_POS);
  endfunction

  assign win      = {prv_q, din};
  assign win_sh   = win << offset_q;
  assign cand_off = win_sh[2*DW-1 -: DW];
  assign off_match = is_comma(cand_off[DW-1 -: 10]);
  assign cnt_d    = cnt_q + 3'd1;
  assign mis_d    = mis_q + 3'd1;

  // Search all 20 offsets; scanning downward leaves the lowest match in s_hit.
  always_comb begin
    hit   = 1'b0;
    s_hit = 5'd0;
    for (int s = DW-1; s >= 0; s--) begin
      if (is_comma(win[2*DW-1-s -: 10])) begin
        hit   = 1'b1;
        s_hit = 5'(s);
      end
    end
  end

  // Alignment FSM plus window/output registers; nothing moves while ena is low
  // except the two per-cycle pulses, which drop to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_HUNT;
      prv_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      offset_q     <= 5'd0;
      comma_det_q  <= 1'b0;
      cnt_q        <= 3'd0;
      mis_q        <= 3'd0;
    end else if (ena) begin
      prv_q        <= din;
      dout_q       <= cand_off;
      dout_valid_q <= (state_q == S_LOCKED);
      comma_det_q  <= hit;
      case (state_q)
        S_HUNT: begin
          if (hit) begin
            offset_q <= s_hit;
            if (LOCK_C == 3'd1) begin
              state_q  <= S_LOCKED;
              locked_q <= 1'b1;
              cnt_q    <= 3'd0;
            end else begin
              state_q <= S_VERIFY;
              cnt_q   <= 3'd1;
            end
          end
        end
        S_VERIFY: begin
          // The latched offset wins even if a lower offset also matches.
          if (off_match) begin
            if (cnt_d == LOCK_C) begin
              state_q  <= S_LOCKED;
              locked_q <= 1'b1;
              cnt_q    <= 3'd0;
            end else begin
              cnt_q <= cnt_d;
            end
          end else if (hit) begin
            offset_q <= s_hit;
            cnt_q    <= 3'd1;
          end
        end
        S_LOCKED: begin
          if (off_match) begin
            mis_q <= 3'd0;
          end else if (hit) begin
            if (mis_d == UNLK_C) begin
              state_q  <= S_HUNT;
              locked_q <= 1'b0;
              mis_q    <= 3'd0;
            end else begin
              mis_q <= mis_d;
            end
          end
        end
        default: begin
          state_q  <= S_HUNT;
          locked_q <= 1'b0;
        end
      endcase
    end else begin
      dout_valid_q <= 1'b0;
      comma_det_q  <= 1'b0;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign locked     = locked_q;
  assign offset     = offset_q;
  assign comma_det  = comma_det_q;

endmodule

// File: tb/tb_comma_aligner_20b.sv
// Directed bench for comma_aligner_20b: each stimulus word carries its
// hand-derived expected outputs into a queue; a monitor checks after each edge.
module tb_comma_aligner_20b;

  localparam logic [19:0] C    = 20'h3EA74; // RD- comma at bit 0 of the word
  localparam logic [19:0] F    = 20'h5A5A5; // filler, never forms a comma
  localparam logic [19:0] W3   = 20'hA7D55; // comma starting 3 bits in
  localparam logic [19:0] W5   = 20'hA9F55; // comma starting 5 bits in
  localparam logic [19:0] JUNK = 20'h0F0F0; // driven while ena=0

  logic        clk = 1'b0;
  logic        rst, ena;
  logic [19:0] din;
  logic [19:0] dout;
  logic        dout_valid, locked, comma_det;
  logic [4:0]  offset;

  int checks   = 0;
  int failures = 0;
  int vec_no   = 0;

  typedef struct {
    int          id;
    logic        cd, dv, lk;
    logic [4:0]  off;
    logic [19:0] dw;
    bit          chk_dout;
  } exp_t;

  exp_t q[$];

  comma_aligner_20b #(.DW(20), .LOCK_CNT(3), .UNLOCK_CNT(4)) dut (
    .clk(clk), .rst(rst), .ena(ena), .din(din),
    .dout(dout), .dout_valid(dout_valid), .locked(locked),
    .offset(offset), .comma_det(comma_det)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input int id, input logic [19:0] act, input logic [19:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d actual=%h expected=%h", nm, id, act, exp);
    end
  endtask

  // Monitor: one expectation per clock edge that stimulus was issued for.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      automatic exp_t e = q.pop_front();
      cmp("comma_det",  e.id, 20'(comma_det),  20'(e.cd));
      cmp("dout_valid", e.id, 20'(dout_valid), 20'(e.dv));
      cmp("locked",     e.id, 20'(locked),     20'(e.lk));
      cmp("offset",     e.id, 20'(offset),     20'(e.off));
      if (e.chk_dout) cmp("dout", e.id, dout, e.dw);
    end
  end

  task automatic step(input bit r, input bit en, input logic [19:0] d,
                      input logic cd, input logic dv, input logic lk,
                      input logic [4:0] off, input logic [19:0] dw, input bit chk);
    exp_t e;
    @(negedge clk);
    rst = r; ena = en; din = d;
    vec_no++;
    e.id = vec_no; e.cd = cd; e.dv = dv; e.lk = lk; e.off = off; e.dw = dw; e.chk_dout = chk;
    q.push_back(e);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 20'h0, 0, 0, 0, 5'd0, 20'h0, 1'b1);
  endtask

  // Comma every 4th word, optionally delayed by sh bits, optionally with an
  // ena=0 cycle before each word. Starts right after reset (prv=0, HUNT).
  task automatic lock_seq(input int sh, input bit gaps);
    logic [19:0] orig [14];
    logic [19:0] w    [14];
    logic [39:0] pair;
    logic        cd, dv, lk, plk;
    logic [4:0]  off, poff;
    logic [19:0] dw, pdw;
    for (int i = 0; i < 14; i++) orig[i] = (i % 4 == 0) ? C : F;
    for (int i = 0; i < 14; i++) begin
      pair = {(i == 0) ? F : orig[i-1], orig[i]};
      pair = pair >> sh;
      w[i] = pair[19:0];
    end
    plk = 0; poff = 5'd0; pdw = 20'h0;
    for (int i = 0; i < 14; i++) begin
      if (gaps && i > 0) step(1'b0, 1'b0, JUNK, 0, 0, plk, poff, pdw, 1'b1);
      cd  = (i > 0) && ((i - 1) % 4 == 0);
      lk  = (i >= 9);
      dv  = (i >= 10);
      off = (i >= 1) ? 5'(sh) : 5'd0;
      dw  = (i == 0) ? 20'h0 : (i == 1) ? w[0] : orig[i-1];
      step(1'b0, 1'b1, w[i], cd, dv, lk, off, dw, 1'b1);
      plk = lk; poff = off; pdw = dw;
    end
  endtask

  initial begin
    rst = 1'b1; ena = 1'b0; din = 20'h0;
    do_reset();
    do_reset();

    // aligned lock at offset 0
    lock_seq(0, 1'b0);

    // three wrong-offset commas, then a correct one clears the miss count
    step(0, 1, W3, 0, 1, 1, 5'd0, F,  1);
    step(0, 1, F,  1, 1, 1, 5'd0, W3, 1);
    step(0, 1, W3, 0, 1, 1, 5'd0, F,  1);
    step(0, 1, F,  1, 1, 1, 5'd0, W3, 1);
    step(0, 1, W3, 0, 1, 1, 5'd0, F,  1);
    step(0, 1, F,  1, 1, 1, 5'd0, W3, 1);
    step(0, 1, C,  0, 1, 1, 5'd0, F,  1);
    step(0, 1, F,  1, 1, 1, 5'd0, C,  1);
    // four consecutive wrong commas drop lock; offset holds until a HUNT hit
    step(0, 1, W3, 0, 1, 1, 5'd0, F,  1);
    step(0, 1, F,  1, 1, 1, 5'd0, W3, 1);
    step(0, 1, W3, 0, 1, 1, 5'd0, F,  1);
    step(0, 1, F,  1, 1, 1, 5'd0, W3, 1);
    step(0, 1, W3, 0, 1, 1, 5'd0, F,  1);
    step(0, 1, F,  1, 1, 1, 5'd0, W3, 1);
    step(0, 1, W3, 0, 1, 1, 5'd0, F,  1);
    step(0, 1, F,  1, 1, 0, 5'd0, W3, 1);
    step(0, 1, W3, 0, 0, 0, 5'd0, F,  1);
    step(0, 1, F,  1, 0, 0, 5'd3, W3, 1);
    // VERIFY: offset jumps 3 -> 0, two commas at 0, then jump to 5 and lock there
    step(0, 1, C,  0, 0, 0, 5'd3, 20'h0, 0);
    step(0, 1, F,  1, 0, 0, 5'd0, 20'h0, 0);
    step(0, 1, C,  0, 0, 0, 5'd0, F,  1);
    step(0, 1, F,  1, 0, 0, 5'd0, C,  1);
    step(0, 1, W5, 0, 0, 0, 5'd0, F,  1);
    step(0, 1, F,  1, 0, 0, 5'd5, W5, 1);
    step(0, 1, W5, 0, 0, 0, 5'd5, 20'h0, 0);
    step(0, 1, F,  1, 0, 0, 5'd5, 20'h3EAAB, 1);
    step(0, 1, W5, 0, 0, 0, 5'd5, 20'h0, 0);
    step(0, 1, F,  1, 0, 1, 5'd5, 20'h3EAAB, 1);
    step(0, 1, F,  0, 1, 1, 5'd5, 20'h4B4AB, 1);

    // sync reset while locked, then a single comma only reaches VERIFY
    step(1, 1, C, 0, 0, 0, 5'd0, 20'h0, 1);
    step(0, 1, C, 0, 0, 0, 5'd0, 20'h0, 1);
    step(0, 1, F, 1, 0, 0, 5'd0, C,     1);

    // lock with ena gaps
    do_reset();
    lock_seq(0, 1'b1);

    // stream delayed by 7 bits across the word boundary
    do_reset();
    lock_seq(7, 1'b0);

    @(negedge clk);
    ena = 1'b0;
    repeat (3) @(negedge clk);
    cmp("queue_drain", 0, 20'(q.size()), 20'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
